// File: rtl/fc_seq_pkg.sv
// Shared types and width helpers for the fc layer-chain training sequencer.
package fc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FWD   = 3'd2,
        BWD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Never returns 0 so that single-value counters still get a 1-bit register.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned phase_w(input int unsigned fd, input int unsigned bk);
        return clog2_min1((fd > bk) ? fd : bk);
    endfunction

    function automatic int unsigned layer_w(input int unsigned n);
        return clog2_min1(n);
    endfunction

endpackage

// File: rtl/osc_divider.sv
// Free-running divided clock: toggles once every OSC_DIV input clocks.
module osc_divider
    import fc_seq_pkg::*;
#(
    parameter int unsigned OSC_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic oscillator_out
);

    localparam int unsigned CW = clog2_min1(OSC_DIV);
    localparam logic [CW-1:0] LAST = CW'(OSC_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_osc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
            r_osc <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_osc <= ~r_osc;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign oscillator_out = r_osc;

endmodule

// File: rtl/fc_train_sequencer.sv
// Sequences sample fetch, forward and backward strobes across a chain of fc layers.
module fc_train_sequencer
    import fc_seq_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned FD_CYCLES  = 3,
    parameter int unsigned BK_CYCLES  = 3,
    parameter int unsigned ITER_W     = 16,
    parameter int unsigned OSC_DIV    = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic                  infer_in,
    input  logic [ITER_W-1:0]     iterations_in,
    input  logic                  sample_valid_in,
    output logic                  sample_req_out,
    output logic [NUM_LAYERS-1:0] fd_prop_out,
    output logic [NUM_LAYERS-1:0] bk_prop_out,
    output logic                  oscillator_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ITER_W-1:0]     iter_count_out
);

    localparam int unsigned PW = phase_w(FD_CYCLES, BK_CYCLES);
    localparam int unsigned LW = layer_w(NUM_LAYERS);
    localparam logic [PW-1:0] FD_LAST    = PW'(FD_CYCLES - 1);
    localparam logic [PW-1:0] BK_LAST    = PW'(BK_CYCLES - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

    state_t                r_state, w_state_nxt;
    logic [LW-1:0]         r_layer, w_layer_nxt;
    logic [PW-1:0]         r_phase, w_phase_nxt;
    logic [ITER_W-1:0]     r_target, w_target_nxt;
    logic [ITER_W-1:0]     r_cnt, w_cnt_nxt;
    logic                  r_infer, w_infer_nxt;
    logic                  r_stop_pend, w_stop_nxt;
    logic                  w_end_iter;
    logic [ITER_W-1:0]     w_cnt_inc;

    logic                  r_req, r_busy, r_done;
    logic [NUM_LAYERS-1:0] r_fd, r_bk;

    assign w_cnt_inc = r_cnt + ITER_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_layer_nxt  = r_layer;
        w_phase_nxt  = r_phase;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_infer_nxt  = r_infer;
        w_stop_nxt   = r_stop_pend;
        w_end_iter   = 1'b0;

        if (stop_in && (r_state == FETCH || r_state == FWD || r_state == BWD))
            w_stop_nxt = 1'b1;

        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_target_nxt = iterations_in;
                    w_infer_nxt  = infer_in;
                    w_cnt_nxt    = '0;
                    w_stop_nxt   = 1'b0;
                    w_state_nxt  = (iterations_in != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (sample_valid_in) begin
                    w_state_nxt = FWD;
                    w_layer_nxt = '0;
                    w_phase_nxt = '0;
                end
            end
            FWD: begin
                if (r_phase == FD_LAST) begin
                    w_phase_nxt = '0;
                    if (r_layer != LAYER_LAST)
                        w_layer_nxt = r_layer + LW'(1);
                    else if (!r_infer)
                        w_state_nxt = BWD;
                    else
                        w_end_iter = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            BWD: begin
                if (r_phase == BK_LAST) begin
                    w_phase_nxt = '0;
                    if (r_layer != '0)
                        w_layer_nxt = r_layer - LW'(1);
                    else
                        w_end_iter = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // A stop arriving on the final strobe edge still ends the run there.
        if (w_end_iter) begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == r_target || w_stop_nxt) ? DONE : FETCH;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_layer     <= '0;
            r_phase     <= '0;
            r_target    <= '0;
            r_cnt       <= '0;
            r_infer     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_req       <= 1'b0;
            r_fd        <= '0;
            r_bk        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_layer     <= w_layer_nxt;
            r_phase     <= w_phase_nxt;
            r_target    <= w_target_nxt;
            r_cnt       <= w_cnt_nxt;
            r_infer     <= w_infer_nxt;
            r_stop_pend <= w_stop_nxt;
            // Outputs are registered from the next state so they align with it.
            r_req       <= (w_state_nxt == FETCH);
            r_fd        <= (w_state_nxt == FWD) ? (ONE_HOT0 << w_layer_nxt) : '0;
            r_bk        <= (w_state_nxt == BWD) ? (ONE_HOT0 << w_layer_nxt) : '0;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    osc_divider #(.OSC_DIV(OSC_DIV)) u_osc (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .oscillator_out (oscillator_out)
    );

    assign sample_req_out = r_req;
    assign fd_prop_out    = r_fd;
    assign bk_prop_out    = r_bk;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign iter_count_out = r_cnt;

endmodule

// File: tb/tb_fc_train_sequencer.sv
// Self-checking bench: table of directed runs, randomized runs and an async-reset sequence.
module tb_fc_train_sequencer;

    localparam int N    = 2;
    localparam int FD   = 3;
    localparam int BK   = 3;
    localparam int IW   = 16;
    localparam int DIV  = 2;
    localparam int MAXC = 600;
    localparam int VW   = 3 + 2 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          infer = 1'b0;
    logic [IW-1:0] iters = '0;
    logic          valid = 1'b0;
    logic          req;
    logic [N-1:0]  fd, bk;
    logic          osc, busy, done;
    logic [IW-1:0] cnt;

    int total = 0;
    int bad   = 0;
    int osc_edges = 0;

    bit        valid_arr [MAXC];
    bit        stop_arr  [MAXC];
    bit        start_arr [MAXC];
    logic [VW-1:0] exp_vec [MAXC];
    int        exp_cnt   [MAXC];

    typedef struct {
        string name;
        int    tgt;
        bit    inf;
        int    vstart;
        int    stopc;
        int    exp_done;
        int    exp_count;
    } vec_t;

    vec_t tbl [6];

    fc_train_sequencer #(
        .NUM_LAYERS (N),
        .FD_CYCLES  (FD),
        .BK_CYCLES  (BK),
        .ITER_W     (IW),
        .OSC_DIV    (DIV)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .start_in        (start),
        .stop_in         (stop),
        .infer_in        (infer),
        .iterations_in   (iters),
        .sample_valid_in (valid),
        .sample_req_out  (req),
        .fd_prop_out     (fd),
        .bk_prop_out     (bk),
        .oscillator_out  (osc),
        .busy_out        (busy),
        .done_out        (done),
        .iter_count_out  (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) osc_edges <= 0;
        else        osc_edges <= osc_edges + 1;
    end

    task automatic check(input string name, input int cyc, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic void put(int t, bit r, logic [N-1:0] f, logic [N-1:0] b,
                                bit d, bit bz, int c);
        if (t < MAXC) begin
            exp_vec[t] = {r, f, b, d, bz};
            exp_cnt[t] = c;
        end
    endfunction

    // Expected per-cycle schedule from the iteration rules: a fetch wait,
    // FD clocks per layer upward, BK clocks per layer downward, then DONE.
    task automatic build_model(input int tgt, input bit inf, input int stopc, output int len);
        int  t = 1;
        int  c = 0;
        bit  v;
        bit  stopped = 0;
        if (tgt != 0) begin
            while (t < MAXC - 2) begin
                do begin
                    put(t, 1, '0, '0, 0, 1, c);
                    v = valid_arr[t];
                    t++;
                end while (!v && t < MAXC - 2);
                for (int l = 0; l < N; l++)
                    for (int k = 0; k < FD; k++) begin put(t, 0, N'(1 << l), '0, 0, 1, c); t++; end
                if (!inf)
                    for (int l = N - 1; l >= 0; l--)
                        for (int k = 0; k < BK; k++) begin put(t, 0, '0, N'(1 << l), 0, 1, c); t++; end
                if (stopc >= 1 && stopc <= t - 1) stopped = 1;
                c++;
                if (c == tgt || stopped) break;
            end
        end
        put(t, 0, '0, '0, 1, 1, c); t++;
        put(t, 0, '0, '0, 0, 0, c);
        len = t;
    endtask

    task automatic run_case(input string name, input int tgt, input bit inf, input int vstart,
                            input int stopc, input int exp_done, input int exp_count,
                            input bit rnd);
        int len;
        int seen_done = -1;
        for (int t = 0; t < MAXC; t++) begin
            valid_arr[t] = (vstart < 0) ? ($urandom_range(0, 3) != 0) : (t >= vstart);
            stop_arr[t]  = (stopc > 0 && t == stopc);
            start_arr[t] = rnd && ($urandom_range(0, 7) == 0);
        end
        build_model(tgt, inf, stopc, len);
        @(posedge clk); #1;
        start = 1'b1; iters = IW'(tgt); infer = inf;
        valid = valid_arr[0]; stop = stop_arr[0];
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            check({name, " outs"}, k, {req, fd, bk, done, busy}, exp_vec[k]);
            check({name, " count"}, k, cnt, exp_cnt[k]);
            check({name, " osc"}, k, osc, (osc_edges / DIV) % 2);
            if (done && seen_done < 0) seen_done = k;
            start = (k <= len - 2) ? start_arr[k] : 1'b0;
            iters = IW'($urandom);
            infer = $urandom_range(0, 1);
            valid = valid_arr[k];
            stop  = stop_arr[k];
        end
        start = 1'b0; stop = 1'b0; valid = 1'b0;
        if (exp_done >= 0) begin
            check({name, " done_cycle"}, len, seen_done, exp_done);
            check({name, " final_count"}, len, cnt, exp_count);
        end
        repeat (2) @(posedge clk);
        #1 check({name, " count_held"}, 0, cnt, exp_cnt[len]);
    endtask

    initial begin
        tbl[0] = '{"single",    1,   0, 0,  0, 14, 1};
        tbl[1] = '{"zero",      0,   0, 0,  0,  1, 0};
        tbl[2] = '{"stall",     1,   0, 7,  0, 20, 1};
        tbl[3] = '{"stop",      100, 0, 0, 30, 40, 3};
        tbl[4] = '{"infer2",    2,   1, 0,  0, 15, 2};
        tbl[5] = '{"three",     3,   0, 0,  0, 40, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset outs", 0, {req, fd, bk, done, busy}, 0);
        check("reset count", 0, cnt, 0);
        check("reset osc", 0, osc, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_case(tbl[i].name, tbl[i].tgt, tbl[i].inf, tbl[i].vstart,
                     tbl[i].stopc, tbl[i].exp_done, tbl[i].exp_count, 1'b0);

        for (int i = 0; i < 20; i++)
            run_case("random", $urandom_range(0, 4), $urandom_range(0, 1), -1,
                     ($urandom_range(0, 1) != 0) ? $urandom_range(1, 60) : 0, -1, 0, 1'b1);

        // Async reset in the middle of the backward pass.
        @(posedge clk); #1;
        start = 1'b1; iters = IW'(1); infer = 1'b0; valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("pre_reset bk", 9, bk, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async bk", 9, bk, 0);
        check("async outs", 9, {req, fd, bk, done, busy}, 0);
        check("async count", 9, cnt, 0);
        check("async osc", 9, osc, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_reset idle", 0, {req, fd, bk, done, busy}, 0);
        valid = 1'b0;

        run_case("after_reset", 1, 0, 0, 0, 14, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
